// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_pkg
// Purpose : Shared encodings and types for the five-stage pipeline sequencer:
//           forwarding selects, next-PC selects, FSM states and the per-stage
//           control record carried by the shadow pipe.
// Rev     : 1.0  initial release
// ============================================================================
package pipe_pkg;

    // EX operand source select
    localparam logic [1:0] C_FWD_RF  = 2'b00;
    localparam logic [1:0] C_FWD_WB  = 2'b01;
    localparam logic [1:0] C_FWD_MEM = 2'b10;

    // Next-PC source select
    localparam logic [1:0] C_PC_PLUS4  = 2'b00;
    localparam logic [1:0] C_PC_JUMP   = 2'b01;
    localparam logic [1:0] C_PC_BRANCH = 2'b10;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] wreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
    } stage_ctrl_t;

    localparam stage_ctrl_t C_BUBBLE = '0;

    // A stage can supply a source operand only if it really writes a
    // non-zero register matching that source; $0 is hardwired zero.
    function automatic logic fwd_hit(input logic wr, input logic [4:0] wreg,
                                     input logic [4:0] src);
        return wr && (wreg != 5'd0) && (wreg == src);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_unit.sv
`default_nettype none
// ============================================================================
// Module  : fwd_unit
// Purpose : Combinational forwarding select for one EX source operand.
//           MEM has priority over WB; register 0 never forwards.
// Ports   : src_i        - EX-stage source register number
//           mem_wr_i     - MEM stage valid and writing a register
//           mem_wreg_i   - MEM stage destination register
//           wb_wr_i      - WB stage valid and writing a register
//           wb_wreg_i    - WB stage destination register
//           sel_o        - operand select (regfile / WB / MEM)
// Rev     : 1.0  initial release
// ============================================================================
module fwd_unit
    import pipe_pkg::*;
(
    input  logic [4:0] src_i,
    input  logic       mem_wr_i,
    input  logic [4:0] mem_wreg_i,
    input  logic       wb_wr_i,
    input  logic [4:0] wb_wreg_i,
    output logic [1:0] sel_o
);

    always_comb begin
        sel_o = C_FWD_RF;
        if (fwd_hit(mem_wr_i, mem_wreg_i, src_i)) begin
            sel_o = C_FWD_MEM;
        end else if (fwd_hit(wb_wr_i, wb_wreg_i, src_i)) begin
            sel_o = C_FWD_WB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipe_hazard_ctrl
// Purpose : Hazard / sequencing controller for the five-stage MIPS core.
//           Tracks EX/MEM/WB control in a shadow pipe, generates stage enables
//           and flushes, EX forwarding selects, and freezes the pipe while the
//           data memory is busy (with a timeout and sticky error).
// Ports   : clk, rst_n                    - clock, async active-low reset
//           id_*_i                        - decoded fields of the ID instruction
//           ex_branch_taken_i             - branch in EX resolved taken
//           dmem_ready_i                  - data memory completes this cycle
//           *_en_o, *_flush_o, pc_sel_o   - stage register control
//           fwd_a_o, fwd_b_o              - EX operand selects
//           mem_err_o, stall_cnt_o, flush_cnt_o - debug status
// Rev     : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             id_uses_rs_i,
    input  logic             id_uses_rt_i,
    input  logic [4:0]       id_wreg_i,
    input  logic             id_regwrite_i,
    input  logic             id_memread_i,
    input  logic             id_memwrite_i,
    input  logic             id_jump_i,
    input  logic             ex_branch_taken_i,
    input  logic             dmem_ready_i,
    output logic             pc_en_o,
    output logic             ifid_en_o,
    output logic             idex_en_o,
    output logic             exmem_en_o,
    output logic             memwb_en_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o,
    output logic [1:0]       pc_sel_o,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic             mem_err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int                WAIT_W     = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] C_WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e             r_state_q, w_state_d;
    logic [WAIT_W-1:0]  r_wait_q,  w_wait_d;
    stage_ctrl_t        r_ex_q,    w_ex_d;
    stage_ctrl_t        r_mem_q;
    logic [4:0]         r_ex_rs_q, r_ex_rt_q;
    logic [4:0]         w_ex_rs_d, w_ex_rt_d;
    // WB only needs what forwarding looks at
    logic               r_wb_valid_q;
    logic               r_wb_regwrite_q;
    logic [4:0]         r_wb_wreg_q;
    logic               r_mem_err_q;
    logic [CNT_W-1:0]   r_stall_cnt_q;
    logic [CNT_W-1:0]   r_flush_cnt_q;

    logic w_mem_access;
    logic w_freeze;
    logic w_set_err;
    logic w_load_use;
    logic w_branch;
    logic w_jump;
    logic w_stall_evt;
    logic w_flush_evt;

    // ------------------------------------------------------------------
    // Memory-wait FSM. The freeze is asserted combinationally in the first
    // ready-low cycle so the MEM access is never lost. The wait counter
    // holds the number of ready-low cycles already spent frozen; when it
    // reaches MEM_TIMEOUT the pipe is released regardless of dmem_ready.
    // ------------------------------------------------------------------
    assign w_mem_access = r_mem_q.valid && (r_mem_q.memread || r_mem_q.memwrite);

    always_comb begin
        w_state_d = r_state_q;
        w_wait_d  = r_wait_q;
        w_freeze  = 1'b0;
        w_set_err = 1'b0;
        unique case (r_state_q)
            ST_RUN: begin
                if (w_mem_access && !dmem_ready_i) begin
                    w_freeze  = 1'b1;
                    w_state_d = ST_MEM_WAIT;
                    w_wait_d  = WAIT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready_i) begin
                    w_state_d = ST_RUN;
                    w_wait_d  = '0;
                end else if (r_wait_q == C_WAIT_MAX) begin
                    w_state_d = ST_RUN;
                    w_wait_d  = '0;
                    w_set_err = 1'b1;
                end else begin
                    w_freeze  = 1'b1;
                    w_wait_d  = r_wait_q + 1'b1;
                end
            end
            default: begin
                w_state_d = ST_RUN;
                w_wait_d  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Hazard resolution. Priority: freeze > taken branch > jump > load-use.
    // A redirect discards the ID instruction that would have stalled, so
    // branch and jump both cancel the load-use stall.
    // ------------------------------------------------------------------
    assign w_load_use = r_ex_q.valid && r_ex_q.memread && (r_ex_q.wreg != 5'd0) &&
                        ((id_uses_rs_i && (id_rs_i == r_ex_q.wreg)) ||
                         (id_uses_rt_i && (id_rt_i == r_ex_q.wreg)));
    assign w_branch   = ex_branch_taken_i;
    assign w_jump     = id_valid_i && id_jump_i && !w_branch;

    always_comb begin
        pc_en_o      = 1'b1;
        ifid_en_o    = 1'b1;
        idex_en_o    = 1'b1;
        exmem_en_o   = 1'b1;
        memwb_en_o   = 1'b1;
        ifid_flush_o = 1'b0;
        idex_flush_o = 1'b0;
        pc_sel_o     = C_PC_PLUS4;
        w_stall_evt  = 1'b0;
        w_flush_evt  = 1'b0;
        if (w_freeze) begin
            pc_en_o     = 1'b0;
            ifid_en_o   = 1'b0;
            idex_en_o   = 1'b0;
            exmem_en_o  = 1'b0;
            memwb_en_o  = 1'b0;
            w_stall_evt = 1'b1;
        end else if (w_branch) begin
            pc_sel_o     = C_PC_BRANCH;
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
            w_flush_evt  = 1'b1;
        end else if (w_jump) begin
            pc_sel_o     = C_PC_JUMP;
            ifid_flush_o = 1'b1;
            w_flush_evt  = 1'b1;
        end else if (w_load_use) begin
            pc_en_o      = 1'b0;
            ifid_en_o    = 1'b0;
            idex_flush_o = 1'b1;
            w_stall_evt  = 1'b1;
        end
    end

    // Next EX contents: the ID instruction, or a bubble when flushed / empty
    always_comb begin
        w_ex_d    = C_BUBBLE;
        w_ex_rs_d = 5'd0;
        w_ex_rt_d = 5'd0;
        if (id_valid_i && !idex_flush_o) begin
            w_ex_d.valid    = 1'b1;
            w_ex_d.wreg     = id_wreg_i;
            w_ex_d.regwrite = id_regwrite_i;
            w_ex_d.memread  = id_memread_i;
            w_ex_d.memwrite = id_memwrite_i;
            w_ex_rs_d       = id_rs_i;
            w_ex_rt_d       = id_rt_i;
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q       <= ST_RUN;
            r_wait_q        <= '0;
            r_ex_q          <= C_BUBBLE;
            r_ex_rs_q       <= 5'd0;
            r_ex_rt_q       <= 5'd0;
            r_mem_q         <= C_BUBBLE;
            r_wb_valid_q    <= 1'b0;
            r_wb_regwrite_q <= 1'b0;
            r_wb_wreg_q     <= 5'd0;
            r_mem_err_q     <= 1'b0;
            r_stall_cnt_q   <= '0;
            r_flush_cnt_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_wait_q  <= w_wait_d;
            if (!w_freeze) begin
                r_ex_q          <= w_ex_d;
                r_ex_rs_q       <= w_ex_rs_d;
                r_ex_rt_q       <= w_ex_rt_d;
                r_mem_q         <= r_ex_q;
                r_wb_valid_q    <= r_mem_q.valid;
                r_wb_regwrite_q <= r_mem_q.regwrite;
                r_wb_wreg_q     <= r_mem_q.wreg;
            end
            if (w_set_err) begin
                r_mem_err_q <= 1'b1;
            end
            if (w_stall_evt && (r_stall_cnt_q != '1)) begin
                r_stall_cnt_q <= r_stall_cnt_q + 1'b1;
            end
            if (w_flush_evt && (r_flush_cnt_q != '1)) begin
                r_flush_cnt_q <= r_flush_cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Forwarding
    // ------------------------------------------------------------------
    logic w_mem_wr;
    logic w_wb_wr;

    assign w_mem_wr = r_mem_q.valid && r_mem_q.regwrite;
    assign w_wb_wr  = r_wb_valid_q && r_wb_regwrite_q;

    fwd_unit u_fwd_a (
        .src_i      (r_ex_rs_q),
        .mem_wr_i   (w_mem_wr),
        .mem_wreg_i (r_mem_q.wreg),
        .wb_wr_i    (w_wb_wr),
        .wb_wreg_i  (r_wb_wreg_q),
        .sel_o      (fwd_a_o)
    );

    fwd_unit u_fwd_b (
        .src_i      (r_ex_rt_q),
        .mem_wr_i   (w_mem_wr),
        .mem_wreg_i (r_mem_q.wreg),
        .wb_wr_i    (w_wb_wr),
        .wb_wreg_i  (r_wb_wreg_q),
        .sel_o      (fwd_b_o)
    );

    assign mem_err_o   = r_mem_err_q;
    assign stall_cnt_o = r_stall_cnt_q;
    assign flush_cnt_o = r_flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_hazard_ctrl
// Purpose : Self-checking bench for pipe_hazard_ctrl. Directed instruction
//           sequences with hand-computed expected outputs pushed into a
//           scoreboard queue; a monitor compares them each cycle.
// Rev     : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int C_TIMEOUT = 4;
    localparam int C_CNT_W   = 16;

    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic [4:0] wreg;
        logic       rw;
        logic       mr;
        logic       mw;
        logic       j;
    } instr_t;

    typedef struct packed {
        logic [4:0]  en;     // pc, ifid, idex, exmem, memwb
        logic [1:0]  fl;     // ifid, idex
        logic [1:0]  pcs;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        err;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    typedef struct {
        exp_t e;
        int   id;
    } sb_t;

    localparam logic [4:0] A = 5'b11111;
    localparam logic [4:0] S = 5'b00111;
    localparam logic [4:0] Z = 5'b00000;

    logic             clk = 1'b0;
    logic             rst_n;
    instr_t           r_in;
    logic             br;
    logic             rdy;
    logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic             ifid_flush, idex_flush;
    logic [1:0]       pc_sel, fwd_a, fwd_b;
    logic             mem_err;
    logic [C_CNT_W-1:0] stall_cnt, flush_cnt;

    sb_t  q[$];
    sb_t  r_pop;
    exp_t w_act;
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (C_TIMEOUT),
        .CNT_W       (C_CNT_W)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .id_valid_i        (r_in.v),
        .id_rs_i           (r_in.rs),
        .id_rt_i           (r_in.rt),
        .id_uses_rs_i      (r_in.urs),
        .id_uses_rt_i      (r_in.urt),
        .id_wreg_i         (r_in.wreg),
        .id_regwrite_i     (r_in.rw),
        .id_memread_i      (r_in.mr),
        .id_memwrite_i     (r_in.mw),
        .id_jump_i         (r_in.j),
        .ex_branch_taken_i (br),
        .dmem_ready_i      (rdy),
        .pc_en_o           (pc_en),
        .ifid_en_o         (ifid_en),
        .idex_en_o         (idex_en),
        .exmem_en_o        (exmem_en),
        .memwb_en_o        (memwb_en),
        .ifid_flush_o      (ifid_flush),
        .idex_flush_o      (idex_flush),
        .pc_sel_o          (pc_sel),
        .fwd_a_o           (fwd_a),
        .fwd_b_o           (fwd_b),
        .mem_err_o         (mem_err),
        .stall_cnt_o       (stall_cnt),
        .flush_cnt_o       (flush_cnt)
    );

    assign w_act = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                    ifid_flush, idex_flush, pc_sel, fwd_a, fwd_b,
                    mem_err, stall_cnt, flush_cnt};

    // Instruction builders
    function automatic instr_t i_nop();
        return '0;
    endfunction

    function automatic instr_t i_alu(input logic [4:0] rd, input logic [4:0] rs,
                                     input logic [4:0] rt);
        instr_t x = '0;
        x.v = 1'b1; x.rs = rs; x.rt = rt; x.urs = 1'b1; x.urt = 1'b1;
        x.wreg = rd; x.rw = 1'b1;
        return x;
    endfunction

    function automatic instr_t i_lw(input logic [4:0] rt, input logic [4:0] base);
        instr_t x = '0;
        x.v = 1'b1; x.rs = base; x.rt = rt; x.urs = 1'b1;
        x.wreg = rt; x.rw = 1'b1; x.mr = 1'b1;
        return x;
    endfunction

    function automatic instr_t i_sw(input logic [4:0] base, input logic [4:0] rt);
        instr_t x = '0;
        x.v = 1'b1; x.rs = base; x.rt = rt; x.urs = 1'b1; x.urt = 1'b1;
        x.mw = 1'b1;
        return x;
    endfunction

    function automatic instr_t i_j();
        instr_t x = '0;
        x.v = 1'b1; x.j = 1'b1;
        return x;
    endfunction

    // Drive one cycle of inputs and queue the outputs expected in that cycle
    task automatic step(input instr_t ins, input logic b, input logic rd,
                        input logic rn, input logic [4:0] en, input logic [1:0] fl,
                        input logic [1:0] pcs, input logic [1:0] fa,
                        input logic [1:0] fb, input logic err,
                        input int sc, input int fc);
        sb_t s;
        @(posedge clk);
        #1;
        r_in  = ins;
        br    = b;
        rdy   = rd;
        rst_n = rn;
        s.e.en  = en;
        s.e.fl  = fl;
        s.e.pcs = pcs;
        s.e.fa  = fa;
        s.e.fb  = fb;
        s.e.err = err;
        s.e.sc  = 16'(sc);
        s.e.fc  = 16'(fc);
        s.id    = cyc;
        q.push_back(s);
        cyc++;
    endtask

    // Monitor: outputs are combinational, compare mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                r_pop = q.pop_front();
                n_checks++;
                if (w_act !== r_pop.e) begin
                    n_err++;
                    $display("FAIL cyc%0d outputs: got en=%b fl=%b pcs=%b fa=%b fb=%b err=%b sc=%0d fc=%0d want en=%b fl=%b pcs=%b fa=%b fb=%b err=%b sc=%0d fc=%0d",
                             r_pop.id, w_act.en, w_act.fl, w_act.pcs, w_act.fa, w_act.fb,
                             w_act.err, w_act.sc, w_act.fc,
                             r_pop.e.en, r_pop.e.fl, r_pop.e.pcs, r_pop.e.fa, r_pop.e.fb,
                             r_pop.e.err, r_pop.e.sc, r_pop.e.fc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        r_in  = '0;
        br    = 1'b0;
        rdy   = 1'b1;

        // reset state
        step(i_nop(),         0, 1, 0, A, 2'b00, 2'd0, 2'd0, 2'd0, 0, 0, 0);
        // forwarding: MEM priority over WB
        step(i_alu(3, 1, 2),  0, 1, 1, A, 2'b00, 2'd0, 2'd0, 2'd0, 0, 0, 0);
        step(i_alu(3, 1, 2),  0, 1, 1, A, 2'b00, 2'd0, 2'd0, 2'd0, 0, 0, 0);
        step(i_alu(4, 3, 3),  0, 1, 1, A, 2'b00, 2'd0, 2'd0, 2'd0, 0, 0, 0);
        step(i_nop(),         0, 1, 1, A, 2'b00, 2'd0, 2'd2, 2'd2, 0, 0, 0);
        // forwarding from WB with one independent instruction between
        step(i_alu(6, 7, 8),  0, 1, 1, A, 2'b00, 2'd0, 2'd0, 2'd0, 0, 0, 0);
        step(i_alu(3, 1, 2),  0, 1, 1, A, 2'b00, 2'd0, 2'd0, 2'd0, 0, 0, 0);
        step(i_alu(9, 1, 2),  0, 1, 1, A, 2'b00, 2'd0, 2'd0, 2'd0, 0, 0, 0);
        step(i_alu(4, 3, 3),  0, 1, 1, A, 2'b00, 2'd0, 2'd0, 2'd0, 0, 0, 0);
        step(i_nop(),         0, 1, 1, A, 2'b00, 2'd0, 2'd1, 2'd1, 0, 0, 0);
        step(i_nop(),         0, 1, 1, A, 2'b00, 2'd0, 2'd0, 2'd0, 0, 0, 0);
        step(i_nop(),         0, 1, 1, A, 2'b00, 2'd0, 2'd0, 2'd0, 0, 0, 0);
        // load-use through rt
        step(i_lw(5, 1),      0, 1, 1, A, 2'b00, 2'd0, 2'd0, 2'd0, 0, 0, 0);
        step(i_alu(6, 7, 5),  0, 1, 1, S, 2'b01, 2'd0, 2'd0, 2'd0, 0, 0, 0);
        step(i_alu(6, 7, 5),  0, 1, 1, A, 2'b00, 2'd0, 2'd0, 2'd0, 0, 1, 0);
        step(i_nop(),         0, 1, 1, A, 2'b00, 2'd0, 2'd0, 2'd1, 0, 1, 0);
        // load to $0: no stall
        step(i_lw(0, 1),      0, 1, 1, A, 2'b00, 2'd0, 2'd0, 2'd0, 0, 1, 0);
        step(i_alu(6, 7, 0),  0, 1, 1, A, 2'b00, 2'd0, 2'd0, 2'd0, 0, 1, 0);
        step(i_nop(),         0, 1, 1, A, 2'b00, 2'd0, 2'd0, 2'd0, 0, 1, 0);
        step(i_nop(),         0, 1, 1, A, 2'b00, 2'd0, 2'd0, 2'd0, 0, 1, 0);
        // taken branch with a jump in ID: one flush event
        step(i_j(),           1, 1, 1, A, 2'b11, 2'd2, 2'd0, 2'd0, 0, 1, 0);
        step(i_nop(),         0, 1, 1, A, 2'b00, 2'd0, 2'd0, 2'd0, 0, 1, 1);
        // jump alone
        step(i_j(),           0, 1, 1, A, 2'b10, 2'd1, 2'd0, 2'd0, 0, 1, 1);
        step(i_nop(),         0, 1, 1, A, 2'b00, 2'd0, 2'd0, 2'd0, 0, 1, 2);
        // taken branch overrides a load-use stall
        step(i_lw(5, 1),      0, 1, 1, A, 2'b00, 2'd0, 2'd0, 2'd0, 0, 1, 2);
        step(i_alu(6, 7, 5),  1, 1, 1, A, 2'b11, 2'd2, 2'd0, 2'd0, 0, 1, 2);
        step(i_nop(),         0, 1, 1, A, 2'b00, 2'd0, 2'd0, 2'd0, 0, 1, 3);
        step(i_nop(),         0, 1, 1, A, 2'b00, 2'd0, 2'd0, 2'd0, 0, 1, 3);
        // sw in MEM with 3 ready-low cycles; branch ignored while frozen
        step(i_sw(1, 2),      0, 1, 1, A, 2'b00, 2'd0, 2'd0, 2'd0, 0, 1, 3);
        step(i_nop(),         0, 1, 1, A, 2'b00, 2'd0, 2'd0, 2'd0, 0, 1, 3);
        step(i_alu(9, 1, 2),  0, 0, 1, Z, 2'b00, 2'd0, 2'd0, 2'd0, 0, 1, 3);
        step(i_alu(9, 1, 2),  1, 0, 1, Z, 2'b00, 2'd0, 2'd0, 2'd0, 0, 2, 3);
        step(i_alu(9, 1, 2),  0, 0, 1, Z, 2'b00, 2'd0, 2'd0, 2'd0, 0, 3, 3);
        step(i_alu(9, 1, 2),  0, 1, 1, A, 2'b00, 2'd0, 2'd0, 2'd0, 0, 4, 3);
        step(i_nop(),         0, 1, 1, A, 2'b00, 2'd0, 2'd0, 2'd0, 0, 4, 3);
        // lw in MEM with ready held low: forced release after 4 cycles
        step(i_lw(8, 1),      0, 1, 1, A, 2'b00, 2'd0, 2'd0, 2'd0, 0, 4, 3);
        step(i_nop(),         0, 1, 1, A, 2'b00, 2'd0, 2'd0, 2'd0, 0, 4, 3);
        step(i_nop(),         0, 0, 1, Z, 2'b00, 2'd0, 2'd0, 2'd0, 0, 4, 3);
        step(i_nop(),         0, 0, 1, Z, 2'b00, 2'd0, 2'd0, 2'd0, 0, 5, 3);
        step(i_nop(),         0, 0, 1, Z, 2'b00, 2'd0, 2'd0, 2'd0, 0, 6, 3);
        step(i_nop(),         0, 0, 1, Z, 2'b00, 2'd0, 2'd0, 2'd0, 0, 7, 3);
        step(i_nop(),         0, 0, 1, A, 2'b00, 2'd0, 2'd0, 2'd0, 0, 8, 3);
        step(i_nop(),         0, 0, 1, A, 2'b00, 2'd0, 2'd0, 2'd0, 1, 8, 3);
        step(i_nop(),         0, 1, 1, A, 2'b00, 2'd0, 2'd0, 2'd0, 1, 8, 3);
        // reset asserted in the middle of MEM_WAIT
        step(i_sw(1, 2),      0, 1, 1, A, 2'b00, 2'd0, 2'd0, 2'd0, 1, 8, 3);
        step(i_nop(),         0, 1, 1, A, 2'b00, 2'd0, 2'd0, 2'd0, 1, 8, 3);
        step(i_nop(),         0, 0, 1, Z, 2'b00, 2'd0, 2'd0, 2'd0, 1, 8, 3);
        step(i_nop(),         0, 0, 1, Z, 2'b00, 2'd0, 2'd0, 2'd0, 1, 9, 3);
        step(i_nop(),         0, 0, 0, A, 2'b00, 2'd0, 2'd0, 2'd0, 0, 0, 0);
        step(i_nop(),         0, 0, 1, A, 2'b00, 2'd0, 2'd0, 2'd0, 0, 0, 0);

        for (int k = 0; k < 5 && q.size() > 0; k++) begin
            @(posedge clk);
        end
        if (q.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL drain: %0d expectations never compared, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
